// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared defaults and constants for the 8N1 UART slice.
//   - CAC_* defaults: clock frequency, baud rate, frame and FIFO geometry.
//   - ERR_* receive status codes reported on error_rx.
//   - FSM state types for the receiver and the transmitter.
//   - clks_per_bit(): rounded clock-cycles-per-bit divisor.
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int CAC_CLK_FREQUENCY     = 10_000_000;
  localparam int CAC_UART_BAUDRATE     = 115200;
  localparam int CAC_UART_BITLEN       = 8;
  localparam int CAC_UART_BUFFER_WIDTH = 8;
  localparam int CAC_UART_BUFFER_DEPTH = 16;
  localparam int CAC_UART_ERRORNUM     = 4;

  // Receive status codes
  localparam int ERR_OK      = 0;  // frame received and stored
  localparam int ERR_FRAME   = 1;  // stop bit sampled low
  localparam int ERR_OVERRUN = 2;  // good frame, RX FIFO full, byte dropped
  localparam int ERR_START   = 3;  // start bit not low at its centre

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // Integer division rounded to nearest: 10 MHz / 115200 -> 87.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// ---------------------------------------------------------------------------
// uart_fifo
//   Synchronous first-word-fall-through FIFO used for both UART directions.
//   Ports:
//     clk      in   system clock, rising edge
//     rstb     in   asynchronous active-low reset; clears storage and pointers
//     i_push   in   write i_data (ignored while full)
//     i_data   in   WIDTH-bit write data
//     i_pop    in   discard the head word (ignored while empty)
//     o_head   out  current head word, valid whenever o_empty is low
//     o_full   out  registered full flag
//     o_empty  out  registered empty flag
// ---------------------------------------------------------------------------
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_count_next;

  // Qualified operations: a blocked push or pop leaves everything untouched.
  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && !r_empty;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + (AW+1)'(1);
      2'b01:   w_count_next = r_count - (AW+1)'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);  // wraps modulo DEPTH
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_next;
      // Flags come from the next count so they are correct the cycle after
      // the operation without a combinational path from i_push/i_pop.
      r_full  <= (w_count_next == (AW+1)'(DEPTH));
      r_empty <= (w_count_next == '0);
    end
  end

  // Head is read straight from the array so a freshly written first word
  // appears on o_head together with o_empty falling.
  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/uart.sv
// ---------------------------------------------------------------------------
// uart
//   Full-duplex 8N1 UART, MSB first, with RX and TX FIFOs.
//   Ports:
//     clk        in   system clock, rising edge
//     rstb       in   asynchronous active-low reset
//     rx         in   serial input (idle high, asynchronous to clk)
//     tx         out  serial output (idle high)
//     data_out   out  head of RX FIFO (first-word fall-through)
//     out_full   out  RX FIFO full
//     out_empty  out  RX FIFO empty
//     out_read   in   pop one RX word per clock
//     data_in    in   byte to transmit
//     in_write   in   push data_in into TX FIFO, one word per clock
//     in_full    out  TX FIFO full
//     in_empty   out  TX FIFO empty
//     error_rx   out  status of the last completed RX frame (ERR_* codes)
// ---------------------------------------------------------------------------
module uart
  import uart_pkg::*;
#(
  parameter int BAUDRATE      = CAC_UART_BAUDRATE,
  parameter int CLK_FREQ      = CAC_CLK_FREQUENCY,
  parameter int BITLEN        = CAC_UART_BITLEN,
  parameter int BUFFER_WIDTH  = CAC_UART_BUFFER_WIDTH,
  parameter int BUFFER_LENGTH = CAC_UART_BUFFER_DEPTH,
  parameter int ERRORNUM      = CAC_UART_ERRORNUM
) (
  input  logic                        clk,
  input  logic                        rstb,
  input  logic                        rx,
  output logic                        tx,
  output logic [BITLEN-1:0]           data_out,
  output logic                        out_full,
  output logic                        out_empty,
  input  logic                        out_read,
  input  logic [BITLEN-1:0]           data_in,
  input  logic                        in_write,
  output logic                        in_full,
  output logic                        in_empty,
  output logic [$clog2(ERRORNUM)-1:0] error_rx
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUDRATE);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(BITLEN);
  localparam int ERR_W        = $clog2(ERRORNUM);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITLEN - 1);

  // -------------------------------------------------------------------------
  // FIFOs
  // -------------------------------------------------------------------------
  logic                    w_rx_push;
  logic [BUFFER_WIDTH-1:0] w_rx_head;
  logic                    w_rx_full;
  logic                    w_rx_empty;

  logic                    w_tx_pop;
  logic [BUFFER_WIDTH-1:0] w_tx_head;
  logic                    w_tx_full;
  logic                    w_tx_empty;

  logic [BITLEN-1:0]       r_rx_shift;

  uart_fifo #(
    .WIDTH (BUFFER_WIDTH),
    .DEPTH (BUFFER_LENGTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rstb    (rstb),
    .i_push  (w_rx_push),
    .i_data  (r_rx_shift),
    .i_pop   (out_read),
    .o_head  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  uart_fifo #(
    .WIDTH (BUFFER_WIDTH),
    .DEPTH (BUFFER_LENGTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rstb    (rstb),
    .i_push  (in_write),
    .i_data  (data_in),
    .i_pop   (w_tx_pop),
    .o_head  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  assign data_out  = w_rx_head;
  assign out_full  = w_rx_full;
  assign out_empty = w_rx_empty;
  assign in_full   = w_tx_full;
  assign in_empty  = w_tx_empty;

  // -------------------------------------------------------------------------
  // Receiver
  // -------------------------------------------------------------------------
  logic              r_rx_meta;
  logic              r_rx_sync;
  logic              r_rx_prev;
  rx_state_t         r_rx_state;
  rx_state_t         w_rx_state_next;
  logic [CNT_W-1:0]  r_rx_cnt;
  logic [CNT_W-1:0]  w_rx_cnt_next;
  logic [BIT_W-1:0]  r_rx_bit;
  logic [BIT_W-1:0]  w_rx_bit_next;
  logic [BITLEN-1:0] w_rx_shift_next;
  logic [ERR_W-1:0]  r_rx_err;
  logic [ERR_W-1:0]  w_rx_err_next;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      // Synchronizer resets to the idle line level so reset release never
      // looks like a start edge.
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_err   <= '0;
    end else begin
      r_rx_meta  <= rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_state <= w_rx_state_next;
      r_rx_cnt   <= w_rx_cnt_next;
      r_rx_bit   <= w_rx_bit_next;
      r_rx_shift <= w_rx_shift_next;
      r_rx_err   <= w_rx_err_next;
    end
  end

  always_comb begin
    w_rx_state_next = r_rx_state;
    w_rx_cnt_next   = r_rx_cnt + CNT_W'(1);
    w_rx_bit_next   = r_rx_bit;
    w_rx_shift_next = r_rx_shift;
    w_rx_err_next   = r_rx_err;
    w_rx_push       = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_next = '0;
        if (r_rx_prev && !r_rx_sync) begin
          w_rx_state_next = RX_START;
        end
      end
      RX_START: begin
        // Half a bit after the edge we are at the start-bit centre; a line
        // that has already returned high was a glitch, not a frame.
        if (r_rx_cnt == CNT_HALF) begin
          w_rx_cnt_next = '0;
          w_rx_bit_next = '0;
          if (!r_rx_sync) begin
            w_rx_state_next = RX_DATA;
          end else begin
            w_rx_err_next   = ERR_W'(ERR_START);
            w_rx_state_next = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == CNT_LAST) begin
          w_rx_cnt_next = '0;
          // Shift in from the LSB end: the first bit received ends up as MSB.
          w_rx_shift_next = {r_rx_shift[BITLEN-2:0], r_rx_sync};
          if (r_rx_bit == BIT_LAST) begin
            w_rx_state_next = RX_STOP;
          end else begin
            w_rx_bit_next = r_rx_bit + BIT_W'(1);
          end
        end
      end
      RX_STOP: begin
        // Leave at the stop-bit centre so the next start edge can be caught
        // even if the sender runs slightly fast.
        if (r_rx_cnt == CNT_LAST) begin
          w_rx_cnt_next   = '0;
          w_rx_state_next = RX_IDLE;
          if (!r_rx_sync) begin
            w_rx_err_next = ERR_W'(ERR_FRAME);
          end else if (w_rx_full) begin
            w_rx_err_next = ERR_W'(ERR_OVERRUN);
          end else begin
            w_rx_push     = 1'b1;
            w_rx_err_next = ERR_W'(ERR_OK);
          end
        end
      end
      default: begin
        w_rx_state_next = RX_IDLE;
      end
    endcase
  end

  assign error_rx = r_rx_err;

  // -------------------------------------------------------------------------
  // Transmitter
  // -------------------------------------------------------------------------
  tx_state_t         r_tx_state;
  tx_state_t         w_tx_state_next;
  logic [CNT_W-1:0]  r_tx_cnt;
  logic [CNT_W-1:0]  w_tx_cnt_next;
  logic [BIT_W-1:0]  r_tx_bit;
  logic [BIT_W-1:0]  w_tx_bit_next;
  logic [BITLEN-1:0] r_tx_shift;
  logic [BITLEN-1:0] w_tx_shift_next;
  logic              r_tx;
  logic              w_tx_next;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_next;
      r_tx_cnt   <= w_tx_cnt_next;
      r_tx_bit   <= w_tx_bit_next;
      r_tx_shift <= w_tx_shift_next;
      r_tx       <= w_tx_next;
    end
  end

  // The line level is registered; every transition below sets the level
  // the line will carry during the state being entered.
  always_comb begin
    w_tx_state_next = r_tx_state;
    w_tx_cnt_next   = r_tx_cnt + CNT_W'(1);
    w_tx_bit_next   = r_tx_bit;
    w_tx_shift_next = r_tx_shift;
    w_tx_next       = r_tx;
    w_tx_pop        = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt_next = '0;
        w_tx_next     = 1'b1;
        if (!w_tx_empty) begin
          w_tx_pop        = 1'b1;
          w_tx_shift_next = w_tx_head;
          w_tx_state_next = TX_START;
          w_tx_next       = 1'b0;
        end
      end
      TX_START: begin
        if (r_tx_cnt == CNT_LAST) begin
          w_tx_cnt_next   = '0;
          w_tx_bit_next   = '0;
          w_tx_state_next = TX_DATA;
          w_tx_next       = r_tx_shift[BITLEN-1];
        end
      end
      TX_DATA: begin
        if (r_tx_cnt == CNT_LAST) begin
          w_tx_cnt_next = '0;
          if (r_tx_bit == BIT_LAST) begin
            w_tx_state_next = TX_STOP;
            w_tx_next       = 1'b1;
          end else begin
            w_tx_bit_next   = r_tx_bit + BIT_W'(1);
            w_tx_shift_next = {r_tx_shift[BITLEN-2:0], 1'b0};
            w_tx_next       = r_tx_shift[BITLEN-2];
          end
        end
      end
      TX_STOP: begin
        if (r_tx_cnt == CNT_LAST) begin
          w_tx_cnt_next = '0;
          // Chain straight into the next start bit when a word is waiting,
          // so the stop bit is never stretched by an idle cycle.
          if (!w_tx_empty) begin
            w_tx_pop        = 1'b1;
            w_tx_shift_next = w_tx_head;
            w_tx_state_next = TX_START;
            w_tx_next       = 1'b0;
          end else begin
            w_tx_state_next = TX_IDLE;
            w_tx_next       = 1'b1;
          end
        end
      end
      default: begin
        w_tx_state_next = TX_IDLE;
        w_tx_next       = 1'b1;
      end
    endcase
  end

  assign tx = r_tx;

endmodule

// File: tb/tb_uart.sv
`timescale 1ns/1ps
// Self-checking bench for uart: randomized and directed traffic, expected
// bytes queued by the stimulus side, compared by independent monitors.
module tb_uart;

  localparam int CLK_NS = 100;              // 10 MHz
  localparam int CPB    = 87;               // round(10e6 / 115200)
  localparam int BIT_NS = 8680;             // bench-side serial bit time
  localparam int DEPTH  = 16;
  localparam int FRAME_CLKS = 10 * CPB;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       rx = 1'b1;
  logic       tx;
  logic [7:0] data_out;
  logic       out_full;
  logic       out_empty;
  logic       out_read = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       in_write = 1'b0;
  logic       in_full;
  logic       in_empty;
  logic [1:0] error_rx;

  uart dut (
    .clk       (clk),
    .rstb      (rstb),
    .rx        (rx),
    .tx        (tx),
    .data_out  (data_out),
    .out_full  (out_full),
    .out_empty (out_empty),
    .out_read  (out_read),
    .data_in   (data_in),
    .in_write  (in_write),
    .in_full   (in_full),
    .in_empty  (in_empty),
    .error_rx  (error_rx)
  );

  always #(CLK_NS/2) clk = ~clk;

  int         n_vec = 0;
  int         n_bad = 0;
  longint     cyc = 0;
  logic [7:0] tx_q[$];          // bytes expected on tx, in order
  logic [7:0] rx_q[$];          // bytes expected in the RX FIFO, in order
  int         exp_err = 0;      // expected error_rx after the last frame
  longint     tx_start_cyc[$];  // cycle of each observed tx start bit
  bit         tx_busy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected tx level during bit slot j of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[8 - j];
  endfunction

  // ---------------- TX monitor: checks every cycle of every frame --------
  logic [7:0] tm_exp;
  int         tm_bad_k;
  logic       tm_bad_v;
  bit         tm_abort;
  initial begin
    forever begin
      @(negedge clk);
      if (rstb && tx === 1'b0) begin
        tx_busy = 1;
        tx_start_cyc.push_back(cyc);
        if (tx_q.size() == 0) begin
          check("tx_unexpected_frame", 32'd1, 32'd0);
          tm_exp = 8'h00;
        end else begin
          tm_exp = tx_q.pop_front();
        end
        tm_bad_k = -1;
        tm_bad_v = 1'b0;
        tm_abort = 0;
        for (int k = 0; k < FRAME_CLKS; k++) begin
          if (k > 0) @(negedge clk);
          if (!rstb) begin
            tm_abort = 1;
            break;
          end
          if (tx !== frame_bit(tm_exp, k / CPB) && tm_bad_k < 0) begin
            tm_bad_k = k;
            tm_bad_v = tx;
          end
        end
        if (tm_abort) begin
          $display("tx frame %02h aborted by reset", tm_exp);
        end else begin
          n_vec++;
          if (tm_bad_k >= 0) begin
            n_bad++;
            $display("FAIL tx_frame %02h: tx=%b at cycle %0d (bit slot %0d), expected %b",
                     tm_exp, tm_bad_v, tm_bad_k, tm_bad_k / CPB, frame_bit(tm_exp, tm_bad_k / CPB));
          end else begin
            $display("tx frame %02h ok", tm_exp);
          end
        end
        tx_busy = 0;
      end
    end
  end

  // ---------------- RX monitor: compares each popped word ----------------
  logic [7:0] rm_exp;
  initial begin
    forever begin
      @(negedge clk);
      if (rstb && out_read && !out_empty) begin
        if (rx_q.size() == 0) begin
          check("rx_unexpected_word", {24'd0, data_out}, 32'hFFFF_FFFF);
        end else begin
          rm_exp = rx_q.pop_front();
          check("rx_data", {24'd0, data_out}, {24'd0, rm_exp});
          $display("rx pop %02h (expected %02h)", data_out, rm_exp);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 7; i >= 0; i--) begin
      rx = b[i];
      #(BIT_NS);
    end
    rx = stop;
    #(BIT_NS);
    rx = 1'b1;
    #(BIT_NS);  // one idle bit between frames
  endtask

  // Applies the reference rules for one frame, sends it, checks the status.
  task automatic rx_frame(input logic [7:0] b, input logic stop);
    if (!stop) begin
      exp_err = 1;
    end else if (rx_q.size() < DEPTH) begin
      rx_q.push_back(b);
      exp_err = 0;
    end else begin
      exp_err = 2;
    end
    send_rx(b, stop);
    check("error_rx_after_frame", {30'd0, error_rx}, exp_err);
  endtask

  task automatic tx_push(input logic [7:0] b);
    @(posedge clk);
    #1;
    data_in  = b;
    in_write = 1'b1;
    tx_q.push_back(b);
  endtask

  task automatic tx_release();
    @(posedge clk);
    #1;
    in_write = 1'b0;
  endtask

  task automatic read_n(input int n);
    if (n > 0) begin
      @(posedge clk);
      #1;
      out_read = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      out_read = 1'b0;
    end
  endtask

  task automatic wait_tx_idle(input int budget);
    int t;
    t = 0;
    while ((tx_q.size() != 0 || tx_busy) && t < budget) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (t >= budget) begin
      n_bad++;
      $display("FAIL tx_drain_timeout: %0d words pending after %0d cycles, expected 0", tx_q.size(), budget);
    end
  endtask

  // ---------------- main sequence ----------------
  int         t_wait;
  int         n_tx;
  int         n_rx;
  int         starts_before;
  initial begin
    // Reset state
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_in_empty", {31'd0, in_empty}, 32'd1);
    check("reset_out_empty", {31'd0, out_empty}, 32'd1);
    check("reset_in_full", {31'd0, in_full}, 32'd0);
    check("reset_out_full", {31'd0, out_full}, 32'd0);
    check("reset_error_rx", {30'd0, error_rx}, 32'd0);
    check("reset_data_out", {24'd0, data_out}, 32'd0);
    @(posedge clk);
    #1;
    rstb = 1'b1;
    repeat (3) @(posedge clk);

    // TX directed: 5 then 9 on consecutive clocks
    tx_start_cyc.delete();
    tx_push(8'd5);
    tx_push(8'd9);
    tx_release();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("tx_one_word_queued_in_empty", {31'd0, in_empty}, 32'd0);
    t_wait = 0;
    while (tx_start_cyc.size() < 2 && t_wait < 3 * FRAME_CLKS) begin
      @(negedge clk);
      t_wait++;
    end
    check("tx_second_frame_started", tx_start_cyc.size(), 32'd2);
    repeat (2) @(negedge clk);
    check("tx_in_empty_after_second_pop", {31'd0, in_empty}, 32'd1);
    if (tx_start_cyc.size() >= 2)
      check("tx_back_to_back_spacing", 32'(tx_start_cyc[1] - tx_start_cyc[0]), FRAME_CLKS);
    wait_tx_idle(4 * FRAME_CLKS);

    // RX directed: 3 then 6
    rx_frame(8'd3, 1'b1);
    rx_frame(8'd6, 1'b1);
    @(negedge clk);
    check("rx_out_empty_after_two", {31'd0, out_empty}, 32'd0);
    check("rx_head_is_first", {24'd0, data_out}, 32'd3);
    read_n(2);
    repeat (2) @(negedge clk);
    check("rx_out_empty_after_reads", {31'd0, out_empty}, 32'd1);
    check("rx_model_drained", rx_q.size(), 32'd0);

    // Framing error
    rx_frame(8'hA5, 1'b0);
    check("framing_nothing_pushed", {31'd0, out_empty}, 32'd1);

    // False start: 20-clock low pulse
    @(posedge clk);
    rx = 1'b0;
    repeat (20) @(posedge clk);
    rx = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("false_start_error_rx", {30'd0, error_rx}, 32'd3);
    check("false_start_no_push", {31'd0, out_empty}, 32'd1);
    rx_frame(8'h3C, 1'b1);
    @(negedge clk);
    check("after_false_start_frame_accepted", {31'd0, out_empty}, 32'd0);
    read_n(1);
    repeat (2) @(negedge clk);

    // Overrun: DEPTH+1 frames without reading
    for (int i = 0; i < DEPTH; i++) rx_frame(8'($urandom), 1'b1);
    @(negedge clk);
    check("overrun_full_after_16", {31'd0, out_full}, 32'd1);
    rx_frame(8'($urandom), 1'b1);
    @(negedge clk);
    check("overrun_still_full", {31'd0, out_full}, 32'd1);
    read_n(DEPTH);
    repeat (2) @(negedge clk);
    check("overrun_drained_empty", {31'd0, out_empty}, 32'd1);
    check("overrun_drained_not_full", {31'd0, out_full}, 32'd0);
    check("overrun_model_drained", rx_q.size(), 32'd0);

    // Randomized full-duplex rounds
    for (int r = 0; r < 4; r++) begin
      n_tx = $urandom_range(1, 3);
      n_rx = $urandom_range(1, 2);
      fork
        begin
          for (int i = 0; i < n_tx; i++) tx_push(8'($urandom));
          tx_release();
        end
        begin
          for (int i = 0; i < n_rx; i++) rx_frame(8'($urandom), ($urandom_range(0, 4) != 0));
        end
      join
      wait_tx_idle(5 * FRAME_CLKS);
      read_n(rx_q.size());
      repeat (2) @(negedge clk);
      check("random_round_rx_empty", {31'd0, out_empty}, 32'd1);
    end

    // Reset in the middle of a transmission
    tx_push(8'hC3);
    tx_push(8'h7E);
    tx_release();
    repeat (300) @(posedge clk);
    @(negedge clk);
    #20;
    rstb = 1'b0;
    tx_q.delete();
    #1;
    check("midframe_reset_tx_high", {31'd0, tx}, 32'd1);
    check("midframe_reset_in_empty", {31'd0, in_empty}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rstb = 1'b1;
    @(negedge clk);
    starts_before = tx_start_cyc.size();
    repeat (2 * FRAME_CLKS) @(negedge clk);
    check("no_frame_after_reset", tx_start_cyc.size(), starts_before);
    tx_push(8'h81);
    tx_release();
    wait_tx_idle(3 * FRAME_CLKS);

    check("final_tx_queue_empty", tx_q.size(), 32'd0);
    check("final_rx_queue_empty", rx_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #9_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors so far", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule
